// File: rtl/mul_arb.sv
// rtl/mul_arb.sv - two-requester round-robin scheduler around a 4-bit shift-add multiplier
//
// Accepts one multiply at a time from two requesters, runs a W-step shift-add
// sequence and returns the 2W-bit product with a one-cycle done pulse to the owner.
//
// Optional feature macro: MUL_ARB_EARLY_EXIT_EN
//   defined   - finish as soon as the remaining multiplier bits are all zero
//   undefined - fixed W-cycle latency regardless of operands
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous reset, active-low
//   req0/req1    level operation requests
//   a0,b0/a1,b1  multiplicand / multiplier per requester (W bits)
//   gnt0/gnt1    one-cycle accept pulse to the owner
//   done0/done1  one-cycle result-valid pulse to the owner
//   y            product of the last completed operation (2W bits)
//   busy         high while an operation is in flight
module mul_arb #(
  parameter int W = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           req0,
  input  logic [W-1:0]   a0,
  input  logic [W-1:0]   b0,
  input  logic           req1,
  input  logic [W-1:0]   a1,
  input  logic [W-1:0]   b1,
  output logic           gnt0,
  output logic           gnt1,
  output logic           done0,
  output logic           done1,
  output logic [2*W-1:0] y,
  output logic           busy
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] CALC = 1'b1;

  logic [0:0]     state;
  logic           ptr;
  logic           owner;
  logic [2*W-1:0] ra;
  logic [2*W-1:0] acc;
  logic [W-1:0]   rb;
  logic [CW-1:0]  cnt;

  logic           sel1;
  logic [2*W-1:0] sum;
  logic [W-1:0]   rb_next;
  logic           last;

  // Requester 1 wins when it is the only one asking, or both ask and ptr points at it.
  assign sel1    = req1 && (!req0 || ptr);
  assign sum     = acc + (rb[0] ? ra : '0);
  assign rb_next = rb >> 1;

`ifdef MUL_ARB_EARLY_EXIT_EN
  // Nothing left to add once the remaining multiplier bits are zero.
  assign last = (cnt == CW'(W - 1)) || (rb_next == '0);
`else
  assign last = (cnt == CW'(W - 1));
`endif

  assign busy = (state == CALC);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      ptr   <= 1'b0;
      owner <= 1'b0;
      ra    <= '0;
      acc   <= '0;
      rb    <= '0;
      cnt   <= '0;
      y     <= '0;
      gnt0  <= 1'b0;
      gnt1  <= 1'b0;
      done0 <= 1'b0;
      done1 <= 1'b0;
    end else begin
      gnt0  <= 1'b0;
      gnt1  <= 1'b0;
      done0 <= 1'b0;
      done1 <= 1'b0;
      if (state == IDLE) begin
        if (req0 || req1) begin
          owner <= sel1;
          ptr   <= ~sel1;
          ra    <= {{W{1'b0}}, (sel1 ? a1 : a0)};
          rb    <= sel1 ? b1 : b0;
          acc   <= '0;
          cnt   <= '0;
          gnt0  <= ~sel1;
          gnt1  <= sel1;
          state <= CALC;
        end
      end else begin
        acc <= sum;
        ra  <= ra << 1;
        rb  <= rb_next;
        cnt <= cnt + CW'(1);
        if (last) begin
          y     <= sum;
          done0 <= ~owner;
          done1 <= owner;
          state <= IDLE;
        end
      end
    end
  end

endmodule

// File: tb/tb_mul_arb.sv
// tb/tb_mul_arb.sv - directed self-checking bench for mul_arb
module tb_mul_arb;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       req0 = 1'b0, req1 = 1'b0;
  logic [3:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic       gnt0, gnt1, done0, done1, busy;
  logic [7:0] y;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int viol  = 0;

  mul_arb #(.W(4)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .a0(a0), .b0(b0),
    .req1(req1), .a1(a1), .b1(b1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .y(y), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Exclusivity of the pulses, watched for the whole run.
  always @(negedge clk)
    if ((gnt0 && done0) || (gnt1 && done1) || (gnt0 && gnt1) || (done0 && done1))
      viol++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int exp_lat(input logic [3:0] b);
`ifdef MUL_ARB_EARLY_EXIT_EN
    int m = 0;
    for (int i = 0; i < 4; i++) if (b[i]) m = i;
    return m + 1;
`else
    return 4;
`endif
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one operation, wait for the grant and the done, checking latency,
  // busy duration and product. Operands are scrambled right after the grant.
  task automatic run_op(input int who, input logic [3:0] a, input logic [3:0] b,
                        input logic [7:0] ey, input int elat);
    int  n;
    int  k;
    int  bc;
    logic g;
    logic d;
    if (who == 0) begin a0 = a; b0 = b; req0 = 1'b1; end
    else          begin a1 = a; b1 = b; req1 = 1'b1; end
    n = 0;
    g = 1'b0;
    while (!g && n < 20) begin
      step();
      n++;
      g = (who == 0) ? gnt0 : gnt1;
    end
    check("gnt_seen", g, 1);
    check("busy_at_gnt", busy, 1);
    if (who == 0) begin req0 = 1'b0; a0 = ~a; b0 = ~b; end
    else          begin req1 = 1'b0; a1 = ~a; b1 = ~b; end
    k  = 0;
    bc = 1;
    d  = 1'b0;
    while (!d && k < 20) begin
      step();
      k++;
      d = (who == 0) ? done0 : done1;
      if (busy) bc++;
    end
    check("done_seen", d, 1);
    check("latency", k, elat);
    check("busy_cycles", bc, elat);
    check("product", y, ey);
    check("busy_at_done", busy, 0);
  endtask

  initial begin
    int n;
    int t[3];
    logic d;

    repeat (3) @(posedge clk);
    #1;
    check("rst_gnt0", gnt0, 0);
    check("rst_gnt1", gnt1, 0);
    check("rst_done0", done0, 0);
    check("rst_done1", done1, 0);
    check("rst_y", y, 0);
    check("rst_busy", busy, 0);
    rst = 1'b1;

    // Basic operation: 9 * 11 = 99.
    run_op(0, 4'd9, 4'd11, 8'd99, exp_lat(4'd11));

    // Both requesting from reset: requester 0 first, requester 1 right after.
    rst = 1'b0;
    req0 = 1'b1; a0 = 4'd15; b0 = 4'd15;
    req1 = 1'b1; a1 = 4'd3;  b1 = 4'd5;
    step();
    rst = 1'b1;
    n = 0;
    while (!gnt0 && !gnt1 && n < 20) begin step(); n++; end
    check("both_first_gnt0", gnt0, 1);
    check("both_first_gnt1", gnt1, 0);
    req0 = 1'b0;
    n = 0;
    d = 1'b0;
    while (!d && n < 20) begin step(); n++; d = done0; end
    check("both_done0", d, 1);
    check("both_y0", y, 225);
    step();
    check("both_gnt1_next", gnt1, 1);
    req1 = 1'b0;
    n = 0;
    d = 1'b0;
    while (!d && n < 20) begin step(); n++; d = done1; end
    check("both_done1", d, 1);
    check("both_lat1", n, exp_lat(4'd5));
    check("both_y1", y, 15);

    // Sole requester holding req: served back to back.
    step();
    req1 = 1'b1; a1 = 4'd3; b1 = 4'd5;
    for (int i = 0; i < 3; i++) begin
      n = 0;
      while (!gnt1 && n < 20) begin step(); n++; end
      check("stream_gnt1", gnt1, 1);
      t[i] = cyc;
      n = 0;
      while (!done1 && n < 20) begin step(); n++; end
      check("stream_y", y, 15);
    end
    req1 = 1'b0;
    check("stream_gap01", t[1] - t[0], exp_lat(4'd5) + 1);
    check("stream_gap12", t[2] - t[1], exp_lat(4'd5) + 1);
    step();

    // Reset two cycles after the grant discards the operation.
    req0 = 1'b1; a0 = 4'd9; b0 = 4'd11;
    n = 0;
    while (!gnt0 && n < 20) begin step(); n++; end
    check("rstmid_gnt0", gnt0, 1);
    req0 = 1'b0;
    step();
    step();
    rst = 1'b0;
    #1;
    check("rstmid_y", y, 0);
    check("rstmid_busy", busy, 0);
    check("rstmid_gnt0_low", gnt0, 0);
    d = 1'b0;
    for (int i = 0; i < 3; i++) begin step(); d = d | done0; end
    check("rstmid_no_done", d, 0);
    rst = 1'b1;
    run_op(0, 4'd5, 4'd6, 8'd30, exp_lat(4'd6));

    // Zero operands, single-bit and top-bit multipliers.
    run_op(0, 4'd0,  4'd9,  8'd0,   exp_lat(4'd9));
    run_op(0, 4'd15, 4'd0,  8'd0,   exp_lat(4'd0));
    run_op(0, 4'd7,  4'd1,  8'd7,   exp_lat(4'd1));
    run_op(1, 4'd15, 4'd8,  8'd120, exp_lat(4'd8));
    run_op(1, 4'd15, 4'd15, 8'd225, exp_lat(4'd15));

    check("pulse_exclusive", viol, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
